// File: rtl/core_mem_lsu.sv
// core_mem_lsu: memory stage / load-store unit between execute and writeback.
//   Issues data-bus requests (req/ack), builds byte enables and lane-replicated
//   store data, extracts and extends load data, flags uncacheable addresses,
//   stalls upstream while a transfer is outstanding, and reports misaligned
//   accesses and bus timeouts.
//   Ports: clk/rst (async, active-high); mem_* from execute and hazard unit;
//   uc_base_in/uc_limit_in window table; dmem_* data bus; mem_stall_out,
//   mem_misalign_out, mem_timeout_out status; wb_*_reg_out writeback registers.
module core_mem_lsu #(
   parameter int XLEN    = 32,
   parameter int NREGION = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_enb,
   input  logic                    mem_kill,
   input  logic                    mem_vld_in,
   input  logic [1:0]              mem_op_in,
   input  logic [1:0]              mem_size_in,
   input  logic                    mem_uns_in,
   input  logic [XLEN-1:0]         mem_addr_in,
   input  logic [XLEN-1:0]         mem_wdata_in,
   input  logic [XLEN-1:0]         mem_alu_result_in,
   input  logic [4:0]              mem_rd_in,
   input  logic                    mem_we_rf_in,
   input  logic [NREGION*XLEN-1:0] uc_base_in,
   input  logic [NREGION*XLEN-1:0] uc_limit_in,
   output logic                    dmem_req_out,
   output logic                    dmem_we_out,
   output logic [XLEN-1:0]         dmem_addr_out,
   output logic [XLEN-1:0]         dmem_wdata_out,
   output logic [XLEN/8-1:0]       dmem_be_out,
   output logic                    dmem_uncache_out,
   input  logic                    dmem_ack_in,
   input  logic [XLEN-1:0]         dmem_rdata_in,
   output logic                    mem_stall_out,
   output logic                    mem_misalign_out,
   output logic                    mem_timeout_out,
   output logic                    wb_vld_reg_out,
   output logic                    wb_we_reg_out,
   output logic [4:0]              wb_rd_reg_out,
   output logic [XLEN-1:0]         wb_data_reg_out
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
   state_t state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic is_ld, is_st, legal, aligned, misalign, busy, issue, to, req_c, uc_c;
   logic r_we, r_uc;
   logic [OW-1:0] off;
   logic [7:0] m8;
   logic [6:0] bits, sl;
   logic [NB-1:0] be_c, r_be;
   logic [XLEN-1:0] addr_c, wdata_c, r_addr, r_wdata, sh, tmp, sx, ld_data;
   logic signed [XLEN-1:0] stmp;
   always_comb begin
      is_ld    = mem_op_in == 2'b01;
      is_st    = mem_op_in == 2'b10;
      legal    = (mem_size_in != 2'b11) || (XLEN == 64);
      aligned  = mem_size_in == 2'd0 ? 1'b1 :
                 mem_size_in == 2'd1 ? ~mem_addr_in[0] :
                 mem_size_in == 2'd2 ? mem_addr_in[1:0] == 2'd0 : mem_addr_in[2:0] == 3'd0;
      misalign = mem_vld_in & (is_ld | is_st) & ~(legal & aligned);
      busy     = state != IDLE;
      // a killed instruction never reaches the bus
      issue    = ~busy & mem_vld_in & (is_ld | is_st) & legal & aligned & ~mem_kill;
      to       = busy & ~dmem_ack_in & (cnt == 16'(TIMEOUT));
      off      = mem_addr_in[OW-1:0];
   end
   always_comb begin
      m8      = mem_size_in == 2'd0 ? 8'h01 : mem_size_in == 2'd1 ? 8'h03 :
                mem_size_in == 2'd2 ? 8'h0F : 8'hFF;
      be_c    = NB'(m8) << off;
      wdata_c = mem_size_in == 2'd0 ? {NB{mem_wdata_in[7:0]}} :
                mem_size_in == 2'd1 ? {(NB/2){mem_wdata_in[15:0]}} :
                mem_size_in == 2'd2 ? {(NB/4){mem_wdata_in[31:0]}} : mem_wdata_in;
      addr_c  = {mem_addr_in[XLEN-1:OW], {OW{1'b0}}};
      uc_c    = 1'b0;
      for (int i = 0; i < NREGION; i++)
         uc_c = uc_c | ((mem_addr_in >= uc_base_in[i*XLEN +: XLEN]) &&
                        (mem_addr_in <= uc_limit_in[i*XLEN +: XLEN]));
   end
   // shift the addressed bytes down, then push the field to the top and back
   // down so one shift performs both zero and sign extension
   always_comb begin
      sh      = dmem_rdata_in >> {off, 3'b000};
      bits    = 7'd8 << mem_size_in;
      sl      = bits >= 7'(XLEN) ? 7'd0 : 7'(XLEN) - bits;
      tmp     = sh << sl;
      stmp    = tmp;
      sx      = stmp >>> sl;
      ld_data = mem_uns_in ? tmp >> sl : sx;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue & ~dmem_ack_in) state_nxt = WAIT;
         WAIT:    if (dmem_ack_in | to) state_nxt = IDLE;
                  else if (mem_kill) state_nxt = DRAIN;
         default: if (dmem_ack_in | to) state_nxt = IDLE;
      endcase
      cnt_nxt = (busy && state_nxt != IDLE) ? cnt + 16'd1 : 16'd0;
   end
   always_comb begin
      req_c            = issue | (busy & ~to);
      dmem_req_out     = req_c & ~rst;
      dmem_we_out      = busy ? r_we : is_st;
      dmem_addr_out    = busy ? r_addr : addr_c;
      dmem_wdata_out   = busy ? r_wdata : wdata_c;
      dmem_be_out      = busy ? r_be : be_c;
      dmem_uncache_out = busy ? r_uc : uc_c;
      mem_stall_out    = req_c & ~dmem_ack_in;
      mem_misalign_out = ~busy & misalign & ~mem_kill;
      mem_timeout_out  = to;
   end
   // request attributes are frozen at issue so the bus sees them stable
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_we    <= 1'b0;
         r_uc    <= 1'b0;
         r_be    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (issue) begin
         r_we    <= is_st;
         r_uc    <= uc_c;
         r_be    <= be_c;
         r_addr  <= addr_c;
         r_wdata <= wdata_c;
      end
   // a kill, or completion of a drained transfer, retires a bubble
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wb_vld_reg_out  <= 1'b0;
         wb_we_reg_out   <= 1'b0;
         wb_rd_reg_out   <= '0;
         wb_data_reg_out <= '0;
      end else if ((mem_kill | state == DRAIN) & ~mem_stall_out) begin
         wb_vld_reg_out  <= 1'b0;
         wb_we_reg_out   <= 1'b0;
         wb_rd_reg_out   <= '0;
         wb_data_reg_out <= '0;
      end else if (mem_enb & ~mem_stall_out) begin
         wb_vld_reg_out  <= mem_vld_in & ~misalign & ~to;
         wb_we_reg_out   <= mem_we_rf_in & ~is_st & ~misalign & ~to;
         wb_rd_reg_out   <= mem_rd_in;
         wb_data_reg_out <= is_ld ? ld_data : mem_alu_result_in;
      end
endmodule

// File: tb/tb_core_mem_lsu.sv
// tb_core_mem_lsu: scoreboard bench for core_mem_lsu (XLEN=32, TIMEOUT=4).
module tb_core_mem_lsu;
   logic clk, rst, mem_enb, mem_kill, mem_vld_in, mem_uns_in, mem_we_rf_in;
   logic [1:0] mem_op_in, mem_size_in;
   logic [31:0] mem_addr_in, mem_wdata_in, mem_alu_result_in, dmem_rdata_in;
   logic [4:0] mem_rd_in;
   logic [63:0] uc_base_in, uc_limit_in;
   logic dmem_req_out, dmem_we_out, dmem_uncache_out, dmem_ack_in;
   logic [31:0] dmem_addr_out, dmem_wdata_out, wb_data_reg_out;
   logic [3:0] dmem_be_out;
   logic mem_stall_out, mem_misalign_out, mem_timeout_out;
   logic wb_vld_reg_out, wb_we_reg_out;
   logic [4:0] wb_rd_reg_out;
   typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic uc;} bus_t;
   typedef struct {logic vld; logic we; logic [4:0] rd; logic [31:0] data; logic chk;} wb_t;
   bus_t bus_q[$];
   wb_t wb_q[$];
   bus_t eb;
   wb_t ew;
   bit wb_pend;
   int vectors = 0, miscompares = 0;
   int nst, nreq, nstall;
   bit seen;
   core_mem_lsu #(.XLEN(32), .NREGION(2), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .mem_enb(mem_enb), .mem_kill(mem_kill),
      .mem_vld_in(mem_vld_in), .mem_op_in(mem_op_in), .mem_size_in(mem_size_in),
      .mem_uns_in(mem_uns_in), .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
      .mem_alu_result_in(mem_alu_result_in), .mem_rd_in(mem_rd_in), .mem_we_rf_in(mem_we_rf_in),
      .uc_base_in(uc_base_in), .uc_limit_in(uc_limit_in),
      .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out),
      .dmem_wdata_out(dmem_wdata_out), .dmem_be_out(dmem_be_out), .dmem_uncache_out(dmem_uncache_out),
      .dmem_ack_in(dmem_ack_in), .dmem_rdata_in(dmem_rdata_in),
      .mem_stall_out(mem_stall_out), .mem_misalign_out(mem_misalign_out), .mem_timeout_out(mem_timeout_out),
      .wb_vld_reg_out(wb_vld_reg_out), .wb_we_reg_out(wb_we_reg_out),
      .wb_rd_reg_out(wb_rd_reg_out), .wb_data_reg_out(wb_data_reg_out));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic uc);
      bus_q.push_back('{we, addr, be, wdata, uc});
   endtask
   task automatic exp_wb(input logic vld, input logic we, input logic [4:0] rd,
                         input logic [31:0] data, input logic chk);
      wb_q.push_back('{vld, we, rd, data, chk});
   endtask
   // monitor: bus beats are checked at req&ack, writeback one cycle after an update
   always @(negedge clk) begin
      if (rst) wb_pend = 1'b0;
      else begin
         if (wb_pend) begin
            if (wb_q.size() == 0) check("wb_extra", 1, 0);
            else begin
               ew = wb_q.pop_front();
               check("wb_vld", wb_vld_reg_out, ew.vld);
               check("wb_we", wb_we_reg_out, ew.we);
               check("wb_rd", wb_rd_reg_out, ew.rd);
               if (ew.chk) check("wb_data", wb_data_reg_out, ew.data);
            end
         end
         if (dmem_req_out && dmem_ack_in) begin
            if (bus_q.size() == 0) check("bus_extra", 1, 0);
            else begin
               eb = bus_q.pop_front();
               check("bus_we", dmem_we_out, eb.we);
               check("bus_addr", dmem_addr_out, eb.addr);
               check("bus_be", dmem_be_out, eb.be);
               check("bus_wdata", dmem_wdata_out, eb.wdata);
               check("bus_uc", dmem_uncache_out, eb.uc);
            end
         end
         wb_pend = mem_enb && !mem_stall_out && (mem_vld_in || mem_kill);
      end
   end
   task automatic drive(input logic [1:0] op, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic [31:0] alu, input logic [4:0] rd);
      mem_vld_in = 1'b1; mem_op_in = op; mem_size_in = size; mem_uns_in = uns;
      mem_addr_in = addr; mem_wdata_in = wdata; dmem_rdata_in = rdata;
      mem_alu_result_in = alu; mem_rd_in = rd;
   endtask
   task automatic xfer(input int d, output int stalls);
      stalls = 0;
      for (int c = 0; c <= d; c++) begin
         dmem_ack_in = (c == d);
         @(negedge clk);
         if (mem_stall_out) stalls++;
         @(posedge clk); #1;
      end
      mem_vld_in = 1'b0; mem_op_in = 2'b00; dmem_ack_in = 1'b0;
   endtask
   initial begin
      rst = 1'b1; mem_enb = 1'b1; mem_kill = 1'b0; mem_we_rf_in = 1'b1;
      mem_vld_in = 1'b0; mem_op_in = 2'b00; mem_size_in = 2'b00; mem_uns_in = 1'b0;
      mem_addr_in = '0; mem_wdata_in = '0; mem_alu_result_in = '0; mem_rd_in = '0;
      dmem_ack_in = 1'b0; dmem_rdata_in = '0;
      uc_base_in  = {32'h0000_0010, 32'h8000_0000};
      uc_limit_in = {32'h0000_0000, 32'h8000_FFFF};
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", dmem_req_out, 0);
      check("rst_stall", mem_stall_out, 0);
      check("rst_wb_vld", wb_vld_reg_out, 0);
      check("rst_wb_data", wb_data_reg_out, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      // lw 0x100, ack on third cycle
      exp_bus(0, 32'h100, 4'hF, 0, 0); exp_wb(1, 1, 5, 32'hDEADBEEF, 1);
      drive(2'b01, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 0, 5); xfer(2, nst);
      check("lw_stall", nst, 2);
      // lb / lbu 0x103
      exp_bus(0, 32'h100, 4'b1000, 0, 0); exp_wb(1, 1, 6, 32'hFFFFFF80, 1);
      drive(2'b01, 2'd0, 0, 32'h103, 0, 32'h80FFFFFF, 0, 6); xfer(1, nst);
      check("lb_stall", nst, 1);
      exp_bus(0, 32'h100, 4'b1000, 0, 0); exp_wb(1, 1, 6, 32'h00000080, 1);
      drive(2'b01, 2'd0, 1, 32'h103, 0, 32'h80FFFFFF, 0, 6); xfer(0, nst);
      check("lbu_stall", nst, 0);
      // lh 0x102 sign-extends the upper half
      exp_bus(0, 32'h100, 4'b1100, 0, 0); exp_wb(1, 1, 8, 32'hFFFF8001, 1);
      drive(2'b01, 2'd1, 0, 32'h102, 0, 32'h8001_0000, 0, 8); xfer(0, nst);
      // sh 0x1234 @0x202, zero wait
      exp_bus(1, 32'h200, 4'b1100, 32'h12341234, 0); exp_wb(1, 0, 7, 32'h55, 1);
      drive(2'b10, 2'd1, 0, 32'h202, 32'hABCD1234, 0, 32'h55, 7); xfer(0, nst);
      check("sh_stall", nst, 0);
      // sb 0xA5 @0x201
      exp_bus(1, 32'h200, 4'b0010, 32'hA5A5A5A5, 0); exp_wb(1, 0, 7, 32'h66, 1);
      drive(2'b10, 2'd0, 0, 32'h201, 32'hFFFFFFA5, 0, 32'h66, 7); xfer(0, nst);
      // misaligned lw 0x101 and illegal dword
      exp_wb(0, 0, 9, 0, 0);
      drive(2'b01, 2'd2, 0, 32'h101, 0, 0, 0, 9);
      @(negedge clk);
      check("mis_req", dmem_req_out, 0);
      check("mis_pulse", mem_misalign_out, 1);
      check("mis_stall", mem_stall_out, 0);
      @(posedge clk); #1; mem_vld_in = 1'b0;
      @(negedge clk);
      check("mis_pulse_end", mem_misalign_out, 0);
      @(posedge clk); #1;
      exp_wb(0, 0, 9, 0, 0);
      drive(2'b01, 2'd3, 0, 32'h200, 0, 0, 0, 9);
      @(negedge clk);
      check("sd_req", dmem_req_out, 0);
      check("sd_pulse", mem_misalign_out, 1);
      @(posedge clk); #1; mem_vld_in = 1'b0;
      // timeout: no ack ever
      exp_wb(0, 0, 10, 0, 0);
      drive(2'b01, 2'd2, 0, 32'h300, 0, 0, 0, 10);
      nreq = 0; nstall = 0; seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (dmem_req_out) nreq++;
         if (mem_stall_out) nstall++;
         if (mem_timeout_out) seen = 1'b1;
         @(posedge clk); #1;
      end
      mem_vld_in = 1'b0;
      check("to_seen", seen, 1);
      check("to_req_cycles", nreq, 5);
      check("to_stall_cycles", nstall, 5);
      @(negedge clk);
      check("to_pulse_end", mem_timeout_out, 0);
      check("to_req_idle", dmem_req_out, 0);
      @(posedge clk); #1;
      // uncacheable window boundaries
      exp_bus(0, 32'h80000010, 4'hF, 0, 1); exp_wb(1, 1, 3, 32'h1, 1);
      drive(2'b01, 2'd2, 0, 32'h80000010, 0, 32'h1, 0, 3); xfer(0, nst);
      exp_bus(0, 32'h7FFFFFFC, 4'hF, 0, 0); exp_wb(1, 1, 3, 32'h2, 1);
      drive(2'b01, 2'd2, 0, 32'h7FFFFFFC, 0, 32'h2, 0, 3); xfer(0, nst);
      exp_bus(1, 32'h8000FFFC, 4'hF, 32'hCAFEF00D, 1); exp_wb(1, 0, 3, 32'h9, 1);
      drive(2'b10, 2'd2, 0, 32'h8000FFFC, 32'hCAFEF00D, 0, 32'h9, 3); xfer(1, nst);
      exp_bus(0, 32'h80010000, 4'hF, 0, 0); exp_wb(1, 1, 3, 32'h3, 1);
      drive(2'b01, 2'd2, 0, 32'h80010000, 0, 32'h3, 0, 3); xfer(0, nst);
      exp_bus(0, 32'h8, 4'hF, 0, 0); exp_wb(1, 1, 3, 32'h4, 1);
      drive(2'b01, 2'd2, 0, 32'h8, 0, 32'h4, 0, 3); xfer(0, nst);
      // kill during WAIT, then ack: bubble retires
      exp_bus(0, 32'h400, 4'hF, 0, 0); exp_wb(0, 0, 0, 0, 1);
      drive(2'b01, 2'd2, 0, 32'h400, 0, 32'h12345678, 0, 11);
      @(posedge clk); #1; mem_kill = 1'b1;
      @(negedge clk);
      check("kill_wait_stall", mem_stall_out, 1);
      @(posedge clk); #1; mem_kill = 1'b0;
      @(negedge clk);
      check("drain_req", dmem_req_out, 1);
      check("drain_stall", mem_stall_out, 1);
      @(posedge clk); #1; dmem_ack_in = 1'b1;
      @(negedge clk);
      check("drain_ack_stall", mem_stall_out, 0);
      @(posedge clk); #1; dmem_ack_in = 1'b0; mem_vld_in = 1'b0;
      // kill in IDLE after a real writeback
      exp_bus(0, 32'h104, 4'hF, 0, 0); exp_wb(1, 1, 12, 32'h11112222, 1);
      drive(2'b01, 2'd2, 0, 32'h104, 0, 32'h11112222, 0, 12); xfer(0, nst);
      exp_wb(0, 0, 0, 0, 1);
      drive(2'b10, 2'd2, 0, 32'h500, 32'h77, 0, 0, 13); mem_kill = 1'b1;
      @(negedge clk);
      check("kill_idle_req", dmem_req_out, 0);
      check("kill_idle_stall", mem_stall_out, 0);
      @(posedge clk); #1; mem_kill = 1'b0; mem_vld_in = 1'b0;
      // reset in the middle of a transfer
      drive(2'b01, 2'd2, 0, 32'h600, 0, 0, 0, 14);
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_rst_req", dmem_req_out, 1);
      #2 rst = 1'b1;
      #1 check("rst_mid_req", dmem_req_out, 0);
      @(posedge clk); #1; rst = 1'b0; mem_vld_in = 1'b0;
      @(negedge clk);
      check("post_rst_req", dmem_req_out, 0);
      check("post_rst_wb_vld", wb_vld_reg_out, 0);
      repeat (3) @(negedge clk);
      check("bus_q_empty", bus_q.size(), 0);
      check("wb_q_empty", wb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
